// File: rtl/ascon_pack.sv
// Shared types and round constants for the Ascon-128 encryption controller.
package ascon_pack;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_AD,
    AD,
    WAIT_PT,
    PT,
    FINAL,
    DONE
  } ctrl_state_t;

  localparam logic [3:0] ROUND_A_FIRST = 4'd0;
  localparam logic [3:0] ROUND_B_FIRST = 4'd6;
  localparam logic [3:0] ROUND_LAST    = 4'd11;

  localparam int BLK_CNT_W = 8;

  // States in which the permutation is running and the round counter advances.
  function automatic logic is_perm_state(ctrl_state_t s);
    return (s == INIT) || (s == AD) || (s == PT) || (s == FINAL);
  endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Round index for the permutation: loads the pa or pb start round, then counts up to the last round.
module ascon_round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       init_a_i,
  input  logic       init_b_i,
  input  logic       en_i,
  output logic [3:0] round_o
);

  logic [3:0] round_q, round_d;

  // Holds at the last round so an idle cycle in a phase cannot wrap the index.
  always_comb begin
    round_d = round_q;
    if (init_a_i) begin
      round_d = ROUND_A_FIRST;
    end else if (init_b_i) begin
      round_d = ROUND_B_FIRST;
    end else if (en_i && (round_q != ROUND_LAST)) begin
      round_d = round_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      round_q <= ROUND_A_FIRST;
    end else begin
      round_q <= round_d;
    end
  end

  assign round_o = round_q;

endmodule

// File: rtl/ascon_fsm_ctrl.sv
// Ascon-128 encryption control FSM: sequences init, AD, PT and final permutation phases.
// Optional sticky protocol-error flag err_o is built when ASCON_FSM_ERR_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// INIT    | pa, rounds 0..11, IV||key||nonce load, key XOR at the end
// WAIT_AD | waiting for a data_valid edge carrying an AD block
// AD      | pb, rounds 6..11, AD absorbed, domain separation on the last block
// WAIT_PT | waiting for a data_valid edge carrying a plaintext block
// PT      | pb, rounds 6..11, plaintext absorbed, cipher block captured
// FINAL   | pa, rounds 0..11, last PT block, key XORs, tag capture
// DONE    | tag valid, end_o held until the next start
module ascon_fsm_ctrl
  import ascon_pack::*;
#(
  parameter int NB_AD_BLOCKS = 1,
  parameter int NB_PT_BLOCKS = 3
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic [3:0] round_o,
  output logic       sel_init_o,
  output logic       en_reg_state_o,
  output logic       en_xor_data_b_o,
  output logic       en_xor_key_b_o,
  output logic       en_xor_key_e_o,
  output logic       en_xor_lsb_e_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       end_o
`ifdef ASCON_FSM_ERR_EN
  ,
  output logic       err_o
`endif
);

  localparam logic [BLK_CNT_W-1:0] AD_LAST = BLK_CNT_W'(NB_AD_BLOCKS - 1);
  localparam logic [BLK_CNT_W-1:0] PT_LAST = BLK_CNT_W'(NB_PT_BLOCKS - 1);

  ctrl_state_t          state_q, state_d;
  logic [BLK_CNT_W-1:0] ad_cnt_q, ad_cnt_d;
  logic [BLK_CNT_W-1:0] pt_cnt_q, pt_cnt_d;
  logic                 dv_prev_q;
  logic                 cipher_valid_q, cipher_valid_d;
  logic                 end_q, end_d;
  logic                 init_a, init_b, rnd_en;
  logic                 dv_edge, phase_last;
  logic [3:0]           round;

  ascon_round_counter u_round (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .init_a_i (init_a),
    .init_b_i (init_b),
    .en_i     (rnd_en),
    .round_o  (round)
  );

  assign dv_edge    = data_valid_i & ~dv_prev_q;
  assign phase_last = (round == ROUND_LAST);
  assign rnd_en     = is_perm_state(state_q);

  always_comb begin
    state_d  = state_q;
    ad_cnt_d = ad_cnt_q;
    pt_cnt_d = pt_cnt_q;
    init_a   = 1'b0;
    init_b   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = INIT;
          init_a   = 1'b1;
          ad_cnt_d = '0;
          pt_cnt_d = '0;
        end
      end
      INIT: begin
        if (phase_last) state_d = WAIT_AD;
      end
      WAIT_AD: begin
        if (dv_edge) begin
          state_d = AD;
          init_b  = 1'b1;
        end
      end
      AD: begin
        if (phase_last) begin
          ad_cnt_d = ad_cnt_q + 1'b1;
          state_d  = (ad_cnt_q == AD_LAST) ? WAIT_PT : WAIT_AD;
        end
      end
      WAIT_PT: begin
        // The last plaintext block goes straight into the finalisation permutation.
        if (dv_edge) begin
          if (pt_cnt_q < PT_LAST) begin
            state_d = PT;
            init_b  = 1'b1;
          end else begin
            state_d = FINAL;
            init_a  = 1'b1;
          end
        end
      end
      PT: begin
        if (phase_last) begin
          pt_cnt_d = pt_cnt_q + 1'b1;
          state_d  = WAIT_PT;
        end
      end
      FINAL: begin
        if (phase_last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_init_o      = 1'b0;
    en_reg_state_o  = 1'b0;
    en_xor_data_b_o = 1'b0;
    en_xor_key_b_o  = 1'b0;
    en_xor_key_e_o  = 1'b0;
    en_xor_lsb_e_o  = 1'b0;
    en_cipher_o     = 1'b0;
    en_tag_o        = 1'b0;
    case (state_q)
      INIT: begin
        en_reg_state_o = 1'b1;
        sel_init_o     = (round == ROUND_A_FIRST);
        en_xor_key_e_o = phase_last;
      end
      AD: begin
        en_reg_state_o  = 1'b1;
        en_xor_data_b_o = (round == ROUND_B_FIRST);
        en_xor_lsb_e_o  = phase_last && (ad_cnt_q == AD_LAST);
      end
      PT: begin
        en_reg_state_o  = 1'b1;
        en_xor_data_b_o = (round == ROUND_B_FIRST);
        en_cipher_o     = (round == ROUND_B_FIRST);
      end
      FINAL: begin
        en_reg_state_o  = 1'b1;
        en_xor_data_b_o = (round == ROUND_A_FIRST);
        en_xor_key_b_o  = (round == ROUND_A_FIRST);
        en_cipher_o     = (round == ROUND_A_FIRST);
        en_xor_key_e_o  = phase_last;
        en_tag_o        = phase_last;
      end
      default: ;
    endcase
  end

  assign cipher_valid_d = en_cipher_o;
  assign end_d          = (state_q == DONE) && !start_i;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q        <= IDLE;
      ad_cnt_q       <= '0;
      pt_cnt_q       <= '0;
      dv_prev_q      <= 1'b0;
      cipher_valid_q <= 1'b0;
      end_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      ad_cnt_q       <= ad_cnt_d;
      pt_cnt_q       <= pt_cnt_d;
      dv_prev_q      <= data_valid_i;
      cipher_valid_q <= cipher_valid_d;
      end_q          <= end_d;
    end
  end

  assign round_o        = round;
  assign cipher_valid_o = cipher_valid_q;
  assign end_o          = end_q;

`ifdef ASCON_FSM_ERR_EN
  logic err_q, err_d;
  logic start_ok, start_bad, dv_bad;

  assign start_ok  = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign start_bad = start_i && !((state_q == IDLE) || (state_q == DONE));
  assign dv_bad    = dv_edge && is_perm_state(state_q);

  always_comb begin
    err_d = err_q;
    if (start_ok) begin
      err_d = 1'b0;
    end else if (start_bad || dv_bad) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// Self-checking bench for ascon_fsm_ctrl: table of phase vectors feeding an expected-output queue.
module tb_ascon_fsm_ctrl;

  localparam int PH_INIT  = 0;
  localparam int PH_AD    = 1;
  localparam int PH_PT    = 2;
  localparam int PH_FINAL = 3;
  localparam int PH_IDLE  = 4;

  localparam int S_SEL = 7, S_REG = 6, S_XD = 5, S_KB = 4;
  localparam int S_KE  = 3, S_LSB = 2, S_CIP = 1, S_TAG = 0;

  typedef struct packed {
    logic       chk_r;
    logic [3:0] rnd;
    logic [7:0] stb;
    logic       cv;
    logic       endv;
    logic       err;
  } exp_t;

  typedef struct {
    logic start;
    logic dv;
    int   hold;
    int   phase;
    int   tail;
    int   poke_start;
    int   poke_dv;
    int   err_at;
  } vec_t;

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i = 1'b0;
  logic       data_valid_i = 1'b0;
  logic [3:0] round_o;
  logic       sel_init_o, en_reg_state_o, en_xor_data_b_o, en_xor_key_b_o;
  logic       en_xor_key_e_o, en_xor_lsb_e_o, en_cipher_o, en_tag_o;
  logic       cipher_valid_o, end_o;
  logic       err_s;
  logic [7:0] stb_s;

  exp_t exp_q[$];
  exp_t ce;
  logic err_lvl = 1'b0;
  logic err_bad;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cv_cnt = 0;
  int   tag_cnt = 0;
  int   cyc = 0;

`ifdef ASCON_FSM_ERR_EN
  logic err_o;
  assign err_s = err_o;
`else
  assign err_s = 1'b0;
`endif

  ascon_fsm_ctrl #(.NB_AD_BLOCKS(1), .NB_PT_BLOCKS(3)) dut (
    .clock_i         (clock_i),
    .resetb_i        (resetb_i),
    .start_i         (start_i),
    .data_valid_i    (data_valid_i),
    .round_o         (round_o),
    .sel_init_o      (sel_init_o),
    .en_reg_state_o  (en_reg_state_o),
    .en_xor_data_b_o (en_xor_data_b_o),
    .en_xor_key_b_o  (en_xor_key_b_o),
    .en_xor_key_e_o  (en_xor_key_e_o),
    .en_xor_lsb_e_o  (en_xor_lsb_e_o),
    .en_cipher_o     (en_cipher_o),
    .en_tag_o        (en_tag_o),
    .cipher_valid_o  (cipher_valid_o),
    .end_o           (end_o)
`ifdef ASCON_FSM_ERR_EN
    ,
    .err_o           (err_o)
`endif
  );

  assign stb_s = {sel_init_o, en_reg_state_o, en_xor_data_b_o, en_xor_key_b_o,
                  en_xor_key_e_o, en_xor_lsb_e_o, en_cipher_o, en_tag_o};

  always #10 clock_i = ~clock_i;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Expected outputs for cycle i after the phase-entry edge.
  function automatic exp_t gen(int ph, int i);
    exp_t e;
    e = '0;
    case (ph)
      PH_INIT: if (i < 12) begin
        e.chk_r      = 1'b1;
        e.rnd        = 4'(i);
        e.stb[S_REG] = 1'b1;
        e.stb[S_SEL] = (i == 0);
        e.stb[S_KE]  = (i == 11);
      end
      PH_AD: if (i < 6) begin
        e.chk_r      = 1'b1;
        e.rnd        = 4'(6 + i);
        e.stb[S_REG] = 1'b1;
        e.stb[S_XD]  = (i == 0);
        e.stb[S_LSB] = (i == 5);
      end
      PH_PT: if (i < 6) begin
        e.chk_r      = 1'b1;
        e.rnd        = 4'(6 + i);
        e.stb[S_REG] = 1'b1;
        e.stb[S_XD]  = (i == 0);
        e.stb[S_CIP] = (i == 0);
        e.cv         = (i == 1);
      end
      PH_FINAL: begin
        if (i < 12) begin
          e.chk_r      = 1'b1;
          e.rnd        = 4'(i);
          e.stb[S_REG] = 1'b1;
          e.stb[S_XD]  = (i == 0);
          e.stb[S_KB]  = (i == 0);
          e.stb[S_CIP] = (i == 0);
          e.stb[S_KE]  = (i == 11);
          e.stb[S_TAG] = (i == 11);
          e.cv         = (i == 1);
        end else begin
          e.endv = (i >= 13);
        end
      end
      PH_IDLE: begin
        e.chk_r = 1'b1;
        e.rnd   = 4'd0;
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(posedge clock_i) begin
    #1;
    cyc = cyc + 1;
    if (cipher_valid_o === 1'b1) cv_cnt = cv_cnt + 1;
    if (en_tag_o === 1'b1) tag_cnt = tag_cnt + 1;
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
`ifdef ASCON_FSM_ERR_EN
      err_bad = (err_s !== ce.err);
`else
      err_bad = 1'b0;
`endif
      n_checks = n_checks + 1;
      if ((ce.chk_r && (round_o !== ce.rnd)) || (stb_s !== ce.stb) ||
          (cipher_valid_o !== ce.cv) || (end_o !== ce.endv) || err_bad) begin
        n_errors = n_errors + 1;
        $display("FAIL cycle %0d outputs: got round=%0d stb=%b cv=%b end=%b err=%b, expected round=%0d(chk=%b) stb=%b cv=%b end=%b err=%b",
                 cyc, round_o, stb_s, cipher_valid_o, end_o, err_s,
                 ce.rnd, ce.chk_r, ce.stb, ce.cv, ce.endv, ce.err);
      end
    end
  end

  task automatic push_n(input int ph, input int first, input int n);
    exp_t e;
    for (int i = first; i < first + n; i++) begin
      e     = gen(ph, i);
      e.err = err_lvl;
      exp_q.push_back(e);
    end
  endtask

  task automatic apply(input vec_t v);
    int   len;
    exp_t e;
    len = ((v.phase == PH_INIT) || (v.phase == PH_FINAL)) ? 12 : 6;
    for (int i = 0; i < len + v.tail; i++) begin
      e = gen(v.phase, i);
      if ((v.phase == PH_INIT) && (i == 0)) err_lvl = 1'b0;
      if (i == v.err_at) err_lvl = 1'b1;
      e.err = err_lvl;
      exp_q.push_back(e);
    end
    for (int k = 0; k < len + v.tail; k++) begin
      start_i      = (v.start && (k < v.hold)) || (k == v.poke_start);
      data_valid_i = (v.dv && (k < v.hold)) || (k == v.poke_dv);
      @(negedge clock_i);
    end
    start_i      = 1'b0;
    data_valid_i = 1'b0;
  endtask

  vec_t tbl[10];
  vec_t tail_v;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 2, PH_INIT,  3, -1, -1,  1};
    tbl[1] = '{1'b0, 1'b1, 2, PH_AD,    2,  7, -1, -1};
    tbl[2] = '{1'b0, 1'b1, 1, PH_PT,    2, -1, -1, -1};
    tbl[3] = '{1'b0, 1'b1, 3, PH_PT,    2, -1, -1, -1};
    tbl[4] = '{1'b0, 1'b1, 1, PH_FINAL, 4, -1, -1, -1};
    tbl[5] = '{1'b1, 1'b0, 1, PH_INIT,  3, -1, -1, -1};
    tbl[6] = '{1'b0, 1'b1, 2, PH_AD,    2,  2, -1,  2};
    tbl[7] = '{1'b0, 1'b1, 1, PH_PT,    2, -1, -1, -1};
    tbl[8] = '{1'b0, 1'b1, 3, PH_PT,    2, -1, -1, -1};
    tbl[9] = '{1'b0, 1'b1, 1, PH_FINAL, 4, -1, -1, -1};
    tail_v = '{1'b1, 1'b0, 1, PH_INIT,  2, -1,  3,  3};

    repeat (2) @(negedge clock_i);
    n_checks = n_checks + 1;
    if ({round_o, stb_s, cipher_valid_o, end_o, err_s} !== 15'd0) begin
      n_errors = n_errors + 1;
      $display("FAIL reset_state: got round=%0d stb=%b cv=%b end=%b err=%b, expected all zero",
               round_o, stb_s, cipher_valid_o, end_o, err_s);
    end
    resetb_i = 1'b1;
    push_n(PH_IDLE, 0, 2);
    repeat (2) @(negedge clock_i);

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i]);
      if (i == 4) begin
        n_checks = n_checks + 1;
        if ((cv_cnt != 3) || (tag_cnt != 1)) begin
          n_errors = n_errors + 1;
          $display("FAIL msg1_pulse_count: got cipher_valid=%0d tag=%0d, expected 3 and 1", cv_cnt, tag_cnt);
        end
      end
    end

    // Reset in the middle of INIT: outputs drop at once, nothing follows release.
    err_lvl = 1'b0;
    push_n(PH_INIT, 0, 6);
    for (int k = 0; k < 6; k++) begin
      start_i = (k == 0);
      @(negedge clock_i);
    end
    start_i = 1'b0;
    #2;
    resetb_i = 1'b0;
    #1;
    n_checks = n_checks + 1;
    if ({round_o, stb_s, cipher_valid_o, end_o, err_s} !== 15'd0) begin
      n_errors = n_errors + 1;
      $display("FAIL async_abort: got round=%0d stb=%b cv=%b end=%b err=%b, expected all zero",
               round_o, stb_s, cipher_valid_o, end_o, err_s);
    end
    push_n(PH_IDLE, 0, 6);
    @(negedge clock_i);
    @(negedge clock_i);
    resetb_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_valid_i = (k == 1);
      @(negedge clock_i);
    end
    data_valid_i = 1'b0;

    apply(tail_v);

    n_checks = n_checks + 1;
    if (exp_q.size() != 0) begin
      n_errors = n_errors + 1;
      $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
